atm_session_ctrl: RTL and testbench

- Sequences one ATM customer session around the combinational account authenticator (4-bit acc_num / 16-bit pin in; index / found / authenticated out).
- Registers card and PIN inputs, drives them to the authenticator, then samples its status one cycle later.
- Counts failed PIN attempts per account, locks accounts after MAX_TRIES failures, enforces an inactivity timeout and reports a session index to the transaction logic.

---
 rtl/atm_pkg.sv | 15 +
 rtl/atm_idle_timer.sv | 17 +
 rtl/atm_session_ctrl.sv | 110 +++++++++++
 tb/tb_atm_session_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// atm_pkg: session states, result codes and authenticator status levels shared by the ATM session logic.
package atm_pkg;
  typedef enum logic [2:0] {IDLE, CHK_ACC, WAIT_PIN, CHK_PIN, SESSION} state_e;
  typedef enum logic [2:0] {
    NONE      = 3'd0,
    AUTH_OK   = 3'd1,
    BAD_PIN   = 3'd2,
    LOCKED    = 3'd3,
    NOT_FOUND = 3'd4,
    TIMEOUT   = 3'd5,
    LOGOUT    = 3'd6
  } result_e;
  localparam logic ACCOUNT_FOUND         = 1'b1;
  localparam logic ACCOUNT_AUTHENTICATED = 1'b1;
endpackage

// File: rtl/atm_idle_timer.sv
// atm_idle_timer: saturating inactivity counter; expire flags the cycle whose edge would complete TIMEOUT_CYCLES idle counts.
module atm_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  assign expire = en && !clr && cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: sequences one ATM session around an external combinational authenticator,
// tracking per-account PIN failures, account locks and the inactivity timeout.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS   = 10,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    card_in,
  input  logic [3:0]              acc_num,
  input  logic                    pin_valid,
  input  logic [15:0]             pin,
  input  logic                    activity,
  input  logic                    logout,
  input  logic                    admin_unlock,
  input  logic [3:0]              unlock_index,
  output logic [3:0]              auth_acc_num,
  output logic [15:0]             auth_pin,
  input  logic [3:0]              auth_index,
  input  logic                    auth_found,
  input  logic                    auth_ok,
  output logic                    session_active,
  output logic [3:0]              session_index,
  output logic [2:0]              result,
  output logic                    result_valid,
  output logic [NUM_ACCOUNTS-1:0] lock_vec
);
  state_e     state, next_state;
  result_e    res_d;
  logic [2:0] fail_cnt [NUM_ACCOUNTS];
  logic [2:0] cur_fail;
  logic       locked_hit, lock_now, expire, timing;
  assign timing         = state == WAIT_PIN || state == SESSION;
  assign session_active = state == SESSION;
  assign lock_now       = cur_fail + 3'd1 == 3'(MAX_TRIES);
  // Counter is held clear outside the timed states, so every entry starts from zero.
  atm_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (timing),
    .clr   (!timing || activity || pin_valid),
    .expire(expire)
  );
  always_comb begin
    cur_fail   = '0;
    locked_hit = 1'b0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      if (4'(i) == session_index) cur_fail = fail_cnt[i];
      if (4'(i) == auth_index) locked_hit = lock_vec[i];
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     next_state = card_in ? CHK_ACC : IDLE;
      CHK_ACC:  next_state = auth_found != ACCOUNT_FOUND || locked_hit ? IDLE : WAIT_PIN;
      WAIT_PIN: next_state = pin_valid ? CHK_PIN : expire ? IDLE : WAIT_PIN;
      CHK_PIN:  next_state = auth_ok == ACCOUNT_AUTHENTICATED ? SESSION : lock_now ? IDLE : WAIT_PIN;
      SESSION:  next_state = logout || expire ? IDLE : SESSION;
      default:  next_state = IDLE;
    endcase
  end
  always_comb begin
    res_d = NONE;
    case (state)
      CHK_ACC:  res_d = auth_found != ACCOUNT_FOUND ? NOT_FOUND : locked_hit ? LOCKED : NONE;
      WAIT_PIN: res_d = expire ? TIMEOUT : NONE;
      CHK_PIN:  res_d = auth_ok == ACCOUNT_AUTHENTICATED ? AUTH_OK : lock_now ? LOCKED : BAD_PIN;
      SESSION:  res_d = logout ? LOGOUT : expire ? TIMEOUT : NONE;
      default:  res_d = NONE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      result        <= NONE;
      result_valid  <= 1'b0;
      auth_acc_num  <= '0;
      auth_pin      <= '0;
      session_index <= '0;
    end else begin
      result       <= res_d;
      result_valid <= res_d != NONE;
      if (state == IDLE && card_in) auth_acc_num <= acc_num;
      if (state == WAIT_PIN && pin_valid) auth_pin <= pin;
      else if (next_state == IDLE && state != IDLE) auth_pin <= '0;
      if (state == CHK_ACC && next_state == WAIT_PIN) session_index <= auth_index;
    end
  // An unlock is applied after the CHK_PIN update so it overrides a same-cycle lock.
  always_ff @(posedge clk)
    if (!rst_n) begin
      lock_vec <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) fail_cnt[i] <= '0;
    end else
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        if (state == CHK_PIN && 4'(i) == session_index) begin
          fail_cnt[i] <= auth_ok == ACCOUNT_AUTHENTICATED ? 3'd0 : cur_fail + 3'd1;
          if (auth_ok != ACCOUNT_AUTHENTICATED && lock_now) lock_vec[i] <= 1'b1;
        end
        if (admin_unlock && 4'(i) == unlock_index) begin
          fail_cnt[i] <= '0;
          lock_vec[i] <= 1'b0;
        end
      end
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: table vectors, directed corner sequences and random traffic checked against a behavioural session model.
module tb_atm_session_ctrl;
  import atm_pkg::*;
  localparam int T = 1000;
  localparam int NV = 25;
  logic clk = 1'b0, rst_n = 1'b0;
  logic card_in = 1'b0, pin_valid = 1'b0, activity = 1'b0, logout = 1'b0, admin_unlock = 1'b0;
  logic [3:0] acc_num = '0, unlock_index = '0;
  logic [15:0] pin = '0;
  logic [3:0] auth_acc_num, auth_index, session_index;
  logic [15:0] auth_pin;
  logic auth_found, auth_ok, session_active, result_valid;
  logic [2:0] result;
  logic [9:0] lock_vec;
  int n_chk = 0, n_fail = 0;

  // account database: acc_num a<10 maps to index 9-a with PIN 734+100*a (acc 5 -> 1234)
  function automatic logic [15:0] pin_of(int a);
    return 16'(734 + 100 * a);
  endfunction
  assign auth_found = auth_acc_num < 4'd10;
  assign auth_index = auth_found ? 4'd9 - auth_acc_num : 4'd0;
  assign auth_ok    = auth_found && auth_pin == pin_of(int'(auth_acc_num));

  atm_session_ctrl dut (
    .clk(clk), .rst_n(rst_n), .card_in(card_in), .acc_num(acc_num), .pin_valid(pin_valid),
    .pin(pin), .activity(activity), .logout(logout), .admin_unlock(admin_unlock),
    .unlock_index(unlock_index), .auth_acc_num(auth_acc_num), .auth_pin(auth_pin),
    .auth_index(auth_index), .auth_found(auth_found), .auth_ok(auth_ok),
    .session_active(session_active), .session_index(session_index), .result(result),
    .result_valid(result_valid), .lock_vec(lock_vec)
  );

  always #5 clk = ~clk;

  // behavioural model: phase 0 idle, 1 card check, 2 awaiting PIN, 3 PIN check, 4 in session
  int m_phase = 0, m_acc = 0, m_sidx = 0, m_idle = 0, m_res = 0;
  int m_fail[10];
  logic [15:0] m_pin = '0;
  logic [9:0] m_lock = '0;

  task automatic model_step();
    m_res = 0;
    if (!rst_n) begin
      m_phase = 0; m_acc = 0; m_sidx = 0; m_idle = 0; m_pin = '0; m_lock = '0;
      foreach (m_fail[i]) m_fail[i] = 0;
      return;
    end
    case (m_phase)
      0: if (card_in) begin m_acc = int'(acc_num); m_phase = 1; end
      1: if (m_acc >= 10) m_res = 4;
         else if (m_lock[9 - m_acc]) m_res = 3;
         else begin m_sidx = 9 - m_acc; m_phase = 2; m_idle = 0; end
      2: if (pin_valid) begin m_pin = pin; m_phase = 3; end
         else if (activity) m_idle = 0;
         else if (m_idle == T - 1) m_res = 5;
         else m_idle++;
      3: if (m_pin == pin_of(m_acc)) begin
           m_fail[m_sidx] = 0; m_res = 1; m_phase = 4; m_idle = 0;
         end else begin
           m_fail[m_sidx]++;
           if (m_fail[m_sidx] == 3) begin m_lock[m_sidx] = 1'b1; m_res = 3; end
           else begin m_res = 2; m_phase = 2; m_idle = 0; end
         end
      4: if (logout) m_res = 6;
         else if (activity || pin_valid) m_idle = 0;
         else if (m_idle == T - 1) m_res = 5;
         else m_idle++;
      default: m_phase = 0;
    endcase
    if (m_res >= 3) begin m_phase = 0; m_pin = '0; end
    if (admin_unlock && unlock_index < 4'd10) begin
      m_lock[unlock_index] = 1'b0;
      m_fail[unlock_index] = 0;
    end
  endtask

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {25'd0, result_valid, result & {3{result_valid}}, session_active, session_index,
            lock_vec, auth_acc_num, auth_pin};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("model", dut_vec(), {25'd0, m_res != 0, 3'(m_res), m_phase == 4, 4'(m_sidx), m_lock,
                              4'(m_acc), m_pin});
    {card_in, pin_valid, activity, logout, admin_unlock} = '0;
  endtask

  task automatic enter(logic [3:0] a);
    card_in = 1'b1; acc_num = a; tick(); tick();
    pin_valid = 1'b1; pin = pin_of(int'(a)); tick(); tick();
    chk("enter", 64'({result_valid, result}), 64'({1'b1, AUTH_OK}));
  endtask

  task automatic bad3();
    card_in = 1'b1; acc_num = 4'd2; tick(); tick();
    repeat (3) begin pin_valid = 1'b1; pin = '0; tick(); tick(); end
  endtask

  task automatic timeout_run(int act_at, int want);
    int hit = 0;
    enter(4'd5);
    for (int k = 1; k <= want + 50 && hit == 0; k++) begin
      activity = k == act_at;
      tick();
      if (result_valid) hit = k;
    end
    chk($sformatf("timeout_at_%0d", want), 64'(hit), 64'(want));
    chk("timeout_code", 64'(result), 64'(TIMEOUT));
  endtask

  typedef struct {
    logic [3:0] ctl;  // {card_in, pin_valid, logout, admin_unlock}
    logic [3:0] acc;
    logic [15:0] pin;
    logic [3:0] uidx;
    logic [2:0] res;
    logic sa;
    logic [3:0] sidx;
    logic [9:0] lock;
    logic [3:0] eacc;
  } vec_t;
  vec_t tbl[NV];

  function automatic vec_t mk(logic [3:0] ctl, logic [3:0] acc, logic [15:0] p, logic [3:0] u,
                              logic [2:0] res, logic sa, logic [3:0] sidx, logic [9:0] lock,
                              logic [3:0] eacc);
    vec_t v;
    v.ctl = ctl; v.acc = acc; v.pin = p; v.uidx = u; v.res = res; v.sa = sa;
    v.sidx = sidx; v.lock = lock; v.eacc = eacc;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(4'b1000, 4'd5,  16'd0,    4'd0,  3'd0, 1'b0, 4'd0, 10'h000, 4'd5);
    tbl[1]  = mk(4'b0000, 4'd0,  16'd0,    4'd0,  3'd0, 1'b0, 4'd4, 10'h000, 4'd5);
    tbl[2]  = mk(4'b0100, 4'd0,  16'd1234, 4'd0,  3'd0, 1'b0, 4'd4, 10'h000, 4'd5);
    tbl[3]  = mk(4'b0000, 4'd0,  16'd0,    4'd0,  3'd1, 1'b1, 4'd4, 10'h000, 4'd5);
    tbl[4]  = mk(4'b0010, 4'd0,  16'd0,    4'd0,  3'd6, 1'b0, 4'd4, 10'h000, 4'd5);
    tbl[5]  = mk(4'b1000, 4'd15, 16'd0,    4'd0,  3'd0, 1'b0, 4'd4, 10'h000, 4'd15);
    tbl[6]  = mk(4'b0000, 4'd0,  16'd0,    4'd0,  3'd4, 1'b0, 4'd4, 10'h000, 4'd15);
    tbl[7]  = mk(4'b1000, 4'd2,  16'd0,    4'd0,  3'd0, 1'b0, 4'd4, 10'h000, 4'd2);
    tbl[8]  = mk(4'b0000, 4'd0,  16'd0,    4'd0,  3'd0, 1'b0, 4'd7, 10'h000, 4'd2);
    tbl[9]  = mk(4'b0100, 4'd0,  16'd0,    4'd0,  3'd0, 1'b0, 4'd7, 10'h000, 4'd2);
    tbl[10] = mk(4'b0000, 4'd0,  16'd0,    4'd0,  3'd2, 1'b0, 4'd7, 10'h000, 4'd2);
    tbl[11] = mk(4'b0100, 4'd0,  16'd0,    4'd0,  3'd0, 1'b0, 4'd7, 10'h000, 4'd2);
    tbl[12] = mk(4'b0000, 4'd0,  16'd0,    4'd0,  3'd2, 1'b0, 4'd7, 10'h000, 4'd2);
    tbl[13] = mk(4'b0100, 4'd0,  16'd0,    4'd0,  3'd0, 1'b0, 4'd7, 10'h000, 4'd2);
    tbl[14] = mk(4'b0000, 4'd0,  16'd0,    4'd0,  3'd3, 1'b0, 4'd7, 10'h080, 4'd2);
    tbl[15] = mk(4'b1000, 4'd2,  16'd0,    4'd0,  3'd0, 1'b0, 4'd7, 10'h080, 4'd2);
    tbl[16] = mk(4'b0000, 4'd0,  16'd0,    4'd0,  3'd3, 1'b0, 4'd7, 10'h080, 4'd2);
    tbl[17] = mk(4'b0001, 4'd0,  16'd0,    4'd7,  3'd0, 1'b0, 4'd7, 10'h000, 4'd2);
    tbl[18] = mk(4'b1000, 4'd2,  16'd0,    4'd0,  3'd0, 1'b0, 4'd7, 10'h000, 4'd2);
    tbl[19] = mk(4'b0000, 4'd0,  16'd0,    4'd0,  3'd0, 1'b0, 4'd7, 10'h000, 4'd2);
    tbl[20] = mk(4'b0100, 4'd0,  16'd934,  4'd0,  3'd0, 1'b0, 4'd7, 10'h000, 4'd2);
    tbl[21] = mk(4'b0000, 4'd0,  16'd0,    4'd0,  3'd1, 1'b1, 4'd7, 10'h000, 4'd2);
    tbl[22] = mk(4'b1000, 4'd3,  16'd0,    4'd0,  3'd0, 1'b1, 4'd7, 10'h000, 4'd2);
    tbl[23] = mk(4'b0001, 4'd0,  16'd0,    4'd12, 3'd0, 1'b1, 4'd7, 10'h000, 4'd2);
    tbl[24] = mk(4'b0010, 4'd0,  16'd0,    4'd0,  3'd6, 1'b0, 4'd7, 10'h000, 4'd2);

    rst_n = 1'b0;
    tick(); tick();
    chk("reset", dut_vec(), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      {card_in, pin_valid, logout, admin_unlock} = tbl[i].ctl;
      acc_num = tbl[i].acc; pin = tbl[i].pin; unlock_index = tbl[i].uidx;
      tick();
      chk($sformatf("vec%0d", i),
          64'({result_valid, result & {3{result_valid}}, session_active, session_index, lock_vec, auth_acc_num}),
          64'({tbl[i].res != 3'd0, tbl[i].res, tbl[i].sa, tbl[i].sidx, tbl[i].lock, tbl[i].eacc}));
    end

    timeout_run(0, T);
    timeout_run(500, T + 500);

    enter(4'd5);
    repeat (T - 1) tick();
    logout = 1'b1; tick();
    chk("logout_wins", 64'({result_valid, result}), 64'({1'b1, LOGOUT}));

    card_in = 1'b1; acc_num = 4'd5; tick(); tick();
    repeat (T - 1) tick();
    pin_valid = 1'b1; pin = pin_of(5); tick();
    chk("pv_at_expiry", 64'(result_valid), 64'd0);
    tick();
    chk("pv_accepted", 64'({result_valid, result}), 64'({1'b1, AUTH_OK}));
    logout = 1'b1; tick();

    card_in = 1'b1; acc_num = 4'd2; tick(); tick();
    repeat (2) begin pin_valid = 1'b1; pin = '0; tick(); tick(); end
    pin_valid = 1'b1; pin = '0; tick();
    admin_unlock = 1'b1; unlock_index = 4'd7; tick();
    chk("unlock_res", 64'({result_valid, result}), 64'({1'b1, LOCKED}));
    chk("unlock_wins", 64'(lock_vec), 64'd0);
    card_in = 1'b1; acc_num = 4'd2; tick(); tick();
    chk("relog_no_lock", 64'(result_valid), 64'd0);
    pin_valid = 1'b1; pin = pin_of(2); tick(); tick();
    chk("relog_ok", 64'({result_valid, result}), 64'({1'b1, AUTH_OK}));
    logout = 1'b1; tick();

    bad3();
    chk("lock_set", 64'(lock_vec), 64'h080);
    enter(4'd5);
    rst_n = 1'b0; tick();
    chk("mid_reset", dut_vec(), 64'd0);
    rst_n = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      rst_n        = $urandom_range(0, 299) != 0;
      card_in      = $urandom_range(0, 3) == 0;
      acc_num      = 4'($urandom_range(0, 11));
      pin_valid    = $urandom_range(0, 2) == 0;
      pin          = $urandom_range(0, 1) != 0 ? pin_of(m_acc) : 16'($urandom);
      activity     = $urandom_range(0, 7) == 0;
      logout       = $urandom_range(0, 19) == 0;
      admin_unlock = $urandom_range(0, 29) == 0;
      unlock_index = 4'($urandom_range(0, 15));
      tick();
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
